// File: rtl/done_seq_pkg.sv
// Shared types, default parameters and parameter legality check for the DONE blink sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package done_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam int unsigned DEF_TICK_DIV  = 1024;
    localparam int unsigned DEF_ON_TICKS  = 4;
    localparam int unsigned DEF_OFF_TICKS = 4;
    localparam int unsigned DEF_GAP_TICKS = 16;

    localparam int unsigned CODE_W      = 4;
    localparam int unsigned FRAME_CNT_W = 8;

    function automatic bit params_legal(input int unsigned tick_div,
                                        input int unsigned on_ticks,
                                        input int unsigned off_ticks,
                                        input int unsigned gap_ticks);
        return (tick_div  >= 2) && (tick_div  <= 65535) &&
               (on_ticks  >= 1) && (on_ticks  <= 255)   &&
               (off_ticks >= 1) && (off_ticks <= 255)   &&
               (gap_ticks >= 1) && (gap_ticks <= 255);
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/done_tick_gen.sv
// Free-running prescaler: one-cycle tick_o on every TICK_DIV-th cfg_clk cycle.
// Latency: first tick after TICK_DIV-1 edges out of reset; tick_o decoded from a register.
// Backpressure: none, free-running.
// Ports: cfg_clk (clock), rst_n (async active-low reset), tick_o (tick strobe).
module done_tick_gen
    import done_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic cfg_clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge cfg_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/done_blink_seq.sv
// Blinks STARTUPE2 USRDONEO code_i times per frame (ON/OFF/GAP tick timing), counting completed frames.
// Latency: usr_done_o is registered; state changes one cycle after the deciding tick (eos_i abort: next cycle).
// Backpressure: none; code_i is sampled only when a frame starts, eos_i low aborts the frame.
// Ports: cfg_clk, rst_n (async active-low), eos_i (enable), code_i (blinks per frame),
//        usr_done_o (to USRDONEO), busy_o (frame in progress), frame_cnt_o (completed frames, wraps).
module done_blink_seq
    import done_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
    parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
    parameter int unsigned OFF_TICKS = DEF_OFF_TICKS,
    parameter int unsigned GAP_TICKS = DEF_GAP_TICKS
) (
    input  logic                   cfg_clk,
    input  logic                   rst_n,
    input  logic                   eos_i,
    input  logic [CODE_W-1:0]      code_i,
    output logic                   usr_done_o,
    output logic                   busy_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

    if (!params_legal(TICK_DIV, ON_TICKS, OFF_TICKS, GAP_TICKS)) begin : g_bad_params
        $error("done_blink_seq: parameter out of legal range");
    end

    // Counter sized for the longest phase; +1 keeps width >= 1 and covers 255 exactly.
    localparam int unsigned TCNT_W = $clog2(max3(ON_TICKS, OFF_TICKS, GAP_TICKS) + 1);
    localparam logic [TCNT_W-1:0] ON_LAST  = TCNT_W'(ON_TICKS - 1);
    localparam logic [TCNT_W-1:0] OFF_LAST = TCNT_W'(OFF_TICKS - 1);
    localparam logic [TCNT_W-1:0] GAP_LAST = TCNT_W'(GAP_TICKS - 1);

    // Reset asserts asynchronously and releases after two clean cfg_clk edges,
    // so the internal reset also drops usr_done_o with no clock running.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge cfg_clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    logic tick;

    done_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .cfg_clk (cfg_clk),
        .rst_n   (rst_int_n),
        .tick_o  (tick)
    );

    state_e                 state_q, state_d;
    logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
    logic [CODE_W-1:0]      rem_q, rem_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
    logic                   done_q;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        rem_d   = rem_q;
        fcnt_d  = fcnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (tick && eos_i && (code_i != '0)) begin
                    state_d = ST_ON;
                    rem_d   = code_i;
                    tcnt_d  = '0;
                end
            end
            ST_ON: begin
                if (tick) begin
                    if (tcnt_q == ON_LAST) begin
                        tcnt_d  = '0;
                        rem_d   = rem_q - CODE_W'(1);
                        // rem_q == 1 means this was the last blink of the frame
                        state_d = (rem_q != CODE_W'(1)) ? ST_OFF : ST_GAP;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            ST_OFF: begin
                if (tick) begin
                    if (tcnt_q == OFF_LAST) begin
                        tcnt_d  = '0;
                        state_d = ST_ON;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (tcnt_q == GAP_LAST) begin
                        tcnt_d  = '0;
                        fcnt_d  = fcnt_q + FRAME_CNT_W'(1);
                        state_d = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tcnt_d  = '0;
            end
        endcase

        // Losing EOS abandons the frame regardless of tick; the frame is not counted.
        if ((state_q != ST_IDLE) && !eos_i) begin
            state_d = ST_IDLE;
            tcnt_d  = '0;
            rem_d   = '0;
            fcnt_d  = fcnt_q;
        end
    end

    always_ff @(posedge cfg_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            rem_q   <= '0;
            fcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            rem_q   <= rem_d;
            fcnt_q  <= fcnt_d;
            // Registered from next state so it tracks state_q == ST_ON exactly.
            done_q  <= (state_d == ST_ON);
        end
    end

    assign usr_done_o  = done_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign frame_cnt_o = fcnt_q;

endmodule

// File: tb/tb_done_blink_seq.sv
// Directed self-checking bench for done_blink_seq with TICK_DIV=4, ON=2, OFF=1, GAP=3.
// Latency: one tick = 4 cycles, so ON=8, OFF=4, GAP=12 cycles, IDLE wait up to 4 cycles.
// Backpressure: n/a.
module tb_done_blink_seq;

    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned ON_TICKS  = 2;
    localparam int unsigned OFF_TICKS = 1;
    localparam int unsigned GAP_TICKS = 3;

    logic       cfg_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       eos_i   = 1'b1;
    logic [3:0] code_i  = 4'd3;
    logic       usr_done_o;
    logic       busy_o;
    logic [7:0] frame_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    done_blink_seq #(
        .TICK_DIV  (TICK_DIV),
        .ON_TICKS  (ON_TICKS),
        .OFF_TICKS (OFF_TICKS),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .cfg_clk     (cfg_clk),
        .rst_n       (rst_n),
        .eos_i       (eos_i),
        .code_i      (code_i),
        .usr_done_o  (usr_done_o),
        .busy_o      (busy_o),
        .frame_cnt_o (frame_cnt_o)
    );

    always #5 cfg_clk = ~cfg_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Counts consecutive negedges at which usr_done_o equals lvl, starting at the current one.
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while ((usr_done_o === lvl) && (n < 200)) begin
            n++;
            @(negedge cfg_clk);
        end
    endtask

    // Negedges from now until usr_done_o is first seen high.
    task automatic wait_rise(output int n);
        n = 0;
        while ((usr_done_o !== 1'b1) && (n < 500)) begin
            @(negedge cfg_clk);
            n++;
        end
    endtask

    // Starting at the first high negedge of a frame, counts its blinks; returns at the
    // first high negedge of the following frame (a low run longer than OFF ends the frame).
    task automatic count_frame(output int blinks);
        int h;
        int l;
        blinks = 0;
        for (int i = 0; i < 20; i++) begin
            run_len(1'b1, h);
            blinks++;
            run_len(1'b0, l);
            if (l != 4) break;
        end
    endtask

    task automatic release_reset();
        @(negedge cfg_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int n;
        int h;
        int l;
        int bad;

        // Reset state, code 3 with EOS high from reset.
        repeat (2) @(negedge cfg_clk);
        check("rst_done", usr_done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_fcnt", frame_cnt_o, 0);
        release_reset();
        // 2 sync edges + 3 prescaler edges -> tick, ON on the 6th edge.
        wait_rise(n);
        check("first_rise", n, 6);
        check("busy_on", busy_o, 1);
        for (int b = 0; b < 3; b++) begin
            run_len(1'b1, h);
            check("c3_on_len", h, 8);
            if (b < 2) begin
                run_len(1'b0, l);
                check("c3_off_len", l, 4);
            end
        end
        // First GAP negedge; frame completes 12 cycles into GAP.
        repeat (11) @(negedge cfg_clk);
        check("c3_fcnt_before", frame_cnt_o, 0);
        @(negedge cfg_clk);
        check("c3_fcnt_after", frame_cnt_o, 1);
        check("c3_idle_busy", busy_o, 0);
        run_len(1'b0, l);
        check("c3_idle_len", l, 4);

        // code 0: stays idle.
        @(negedge cfg_clk);
        rst_n  = 1'b0;
        code_i = 4'd0;
        release_reset();
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge cfg_clk);
            if (usr_done_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        check("c0_activity", bad, 0);
        check("c0_fcnt", frame_cnt_o, 0);

        // code 2, changed to 5 during the first ON.
        @(negedge cfg_clk);
        rst_n  = 1'b0;
        code_i = 4'd2;
        release_reset();
        wait_rise(n);
        check("c2_rise", n, 6);
        code_i = 4'd5;
        count_frame(n);
        check("c2_blinks", n, 2);
        check("c2_fcnt", frame_cnt_o, 1);
        count_frame(n);
        check("c5_blinks", n, 5);
        check("c5_fcnt", frame_cnt_o, 2);

        // Reset mid-ON (frame 3 is in its first ON here).
        repeat (2) @(negedge cfg_clk);
        check("mid_on_done", usr_done_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_done", usr_done_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_fcnt", frame_cnt_o, 0);
        code_i = 4'd3;
        release_reset();
        wait_rise(n);
        check("arst_rise", n, 6);

        // EOS dropped during the second ON of the second code-3 frame.
        count_frame(n);
        check("c3b_blinks", n, 3);
        check("c3b_fcnt", frame_cnt_o, 1);
        run_len(1'b1, h);
        check("abort_on1", h, 8);
        run_len(1'b0, l);
        check("abort_off1", l, 4);
        @(negedge cfg_clk);
        eos_i = 1'b0;
        @(negedge cfg_clk);
        check("abort_done", usr_done_o, 0);
        check("abort_busy", busy_o, 0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge cfg_clk);
            if (usr_done_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        check("abort_stay_idle", bad, 0);
        check("abort_fcnt", frame_cnt_o, 1);

        // 256 frames of code 1: counter wraps, every blink clean.
        @(negedge cfg_clk);
        rst_n  = 1'b0;
        eos_i  = 1'b1;
        code_i = 4'd1;
        release_reset();
        wait_rise(n);
        check("c1_rise", n, 6);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            run_len(1'b1, h);
            run_len(1'b0, l);
            if (h != 8 || l != 16) bad++;
            if (i == 254) check("c1_fcnt_255", frame_cnt_o, 255);
        end
        check("c1_glitches", bad, 0);
        check("c1_fcnt_wrap", frame_cnt_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
